// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: priority-level selection with round-robin tie-break,
// grant hold until done/error/timeout/abort, then a one-cycle release gap.
module dma_channel_arbiter #(
    parameter int CH_CNT      = 7,
    parameter int IDW         = $clog2(CH_CNT),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_CNT-1:0]     ch_en_i,
    input  logic [2*CH_CNT-1:0]   ch_pl_i,
    input  logic [CH_CNT-1:0]     ch_req_i,
    input  logic                  xfer_done_i,
    input  logic                  xfer_err_i,
    output logic [CH_CNT-1:0]     gnt_o,
    output logic [IDW-1:0]        gnt_id_o,
    output logic                  busy_o,
    output logic [CH_CNT-1:0]     ack_o,
    output logic [CH_CNT-1:0]     err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(CH_CNT - 1);
    localparam logic [IDW:0]   CH_WRAP = (IDW+1)'(CH_CNT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        r_state;
    logic [CH_CNT-1:0] r_gnt;
    logic [IDW-1:0]    r_gnt_id;
    logic              r_busy;
    logic [CH_CNT-1:0] r_ack;
    logic [CH_CNT-1:0] r_err;
    logic [IDW-1:0]    r_rr_ptr;
    logic [TW-1:0]     r_cnt;

    logic [CH_CNT-1:0] w_elig;
    logic [1:0]        w_max_pl;
    logic              w_found;
    logic [IDW-1:0]    w_win_id;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_idx;
    logic [CH_CNT-1:0] w_win_oh;
    logic              w_timeout;
    logic              w_abort;
    logic              w_release;
    logic [IDW-1:0]    w_next_ptr;

    // Winner: highest PL among eligible channels, first at/after rr_ptr with wrap.
    always_comb begin
        w_elig   = ch_en_i & ch_req_i;
        w_max_pl = 2'd0;
        w_found  = 1'b0;
        w_win_id = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < CH_CNT; k++) begin
            if (w_elig[k] && (ch_pl_i[2*k +: 2] > w_max_pl)) begin
                w_max_pl = ch_pl_i[2*k +: 2];
            end else begin
                w_max_pl = w_max_pl;
            end
        end
        for (int i = 0; i < CH_CNT; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (w_sum >= CH_WRAP) begin
                w_sum = w_sum - CH_WRAP;
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && w_elig[w_idx] && (ch_pl_i[2*w_idx +: 2] == w_max_pl)) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Release conditions while a grant is held.
    always_comb begin
        w_win_oh   = {{(CH_CNT-1){1'b0}}, 1'b1} << w_win_id;
        w_timeout  = (r_cnt == TO_LAST);
        w_abort    = ((ch_en_i & r_gnt) == {CH_CNT{1'b0}});
        w_release  = xfer_err_i | w_timeout | xfer_done_i | w_abort;
        if (r_gnt_id == ID_LAST) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_gnt_id + IDW'(1);
        end
    end

    // Grant sequencer; ack/err default low so they pulse for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
            r_err    <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_win_oh;
                        r_gnt_id <= w_win_id;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_GRANT;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (!w_timeout) begin
                        r_cnt <= r_cnt + TW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                    if (xfer_err_i || w_timeout) begin
                        r_err <= r_gnt;
                    end else if (xfer_done_i) begin
                        r_ack <= r_gnt;
                    end else begin
                        r_ack <= '0;
                    end
                    if (w_release) begin
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_RELEASE;
                    end else begin
                        r_state  <= S_GRANT;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = r_gnt;
    assign gnt_id_o = r_gnt_id;
    assign busy_o   = r_busy;
    assign ack_o    = r_ack;
    assign err_o    = r_err;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a behavioural model.
module tb_dma_channel_arbiter;

    localparam int CH  = 7;
    localparam int IDW = 3;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   ch_en = '0;
    logic [CH-1:0]   ch_req = '0;
    logic [2*CH-1:0] ch_pl = '0;
    logic            done = 1'b0;
    logic            err = 1'b0;
    logic [CH-1:0]   gnt, ack, errp;
    logic [IDW-1:0]  gid;
    logic            busy;

    int checks = 0;
    int failures = 0;

    dma_channel_arbiter #(.CH_CNT(CH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en_i(ch_en), .ch_pl_i(ch_pl),
        .ch_req_i(ch_req), .xfer_done_i(done), .xfer_err_i(err),
        .gnt_o(gnt), .gnt_id_o(gid), .busy_o(busy), .ack_o(ack), .err_o(errp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]   en;
        logic [CH-1:0]   req;
        logic [2*CH-1:0] pl;
        logic            dn;
        logic            er;
        logic [CH-1:0]   x_gnt;
        int              x_id;
        logic [CH-1:0]   x_ack;
        logic [CH-1:0]   x_err;
    } vec_t;

    vec_t tbl[18];

    // Expected packed outputs {gnt, id (0 when idle), busy, ack, err}.
    function automatic logic [24:0] ex(input logic [CH-1:0] g, input int id,
                                       input logic [CH-1:0] a, input logic [CH-1:0] e);
        logic b;
        logic [IDW-1:0] i3;
        b  = (g != '0);
        i3 = b ? IDW'(id) : '0;
        return {g, i3, b, a, e};
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        logic [24:0] act;
        logic [IDW-1:0] aid;
        aid = busy ? gid : '0;
        act = {gnt, aid, busy, ack, errp};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got gnt=%h id=%0d busy=%b ack=%h err=%h, want gnt=%h id=%0d busy=%b ack=%h err=%h",
                     name, $time, act[24:18], act[17:15], act[14], act[13:7], act[6:0],
                     exp[24:18], exp[17:15], exp[14], exp[13:7], exp[6:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit            m_busy;
    int            m_id, m_held, m_cool, m_rr;
    logic [CH-1:0] m_ack, m_err;

    function automatic int pick(input int rr);
        for (int lvl = 3; lvl >= 0; lvl--) begin
            for (int off = 0; off < CH; off++) begin
                int c;
                c = (rr + off) % CH;
                if (ch_en[c] && ch_req[c] && (int'(ch_pl[2*c +: 2]) == lvl)) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_held = 0; m_cool = 0; m_rr = 0;
        m_ack = '0; m_err = '0;
    endtask

    task automatic model_step();
        int w;
        logic [CH-1:0] me;
        m_ack = '0;
        m_err = '0;
        if (m_cool > 0) begin
            m_cool--;
        end else if (!m_busy) begin
            w = pick(m_rr);
            if (w >= 0) begin
                m_busy = 1; m_id = w; m_held = 0;
            end
        end else begin
            m_held++;
            me = '0;
            me[m_id] = 1'b1;
            if (err || m_held == TO) m_err = me;
            else if (done)            m_ack = me;
            if (err || m_held == TO || done || !ch_en[m_id]) begin
                m_busy = 0; m_cool = 1; m_rr = (m_id + 1) % CH;
            end
        end
    endtask

    function automatic logic [CH-1:0] oh(input int id);
        logic [CH-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        ch_en = '0; ch_req = '0; ch_pl = '0; done = 1'b0; err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [CH-1:0] en, input logic [CH-1:0] req,
                                input logic [2*CH-1:0] pl, input logic dn,
                                input logic [CH-1:0] g, input int id,
                                input logic [CH-1:0] a);
        vec_t v;
        v.en = en; v.req = req; v.pl = pl; v.dn = dn; v.er = 1'b0;
        v.x_gnt = g; v.x_id = id; v.x_ack = a; v.x_err = '0;
        return v;
    endfunction

    int rr_exp[6] = '{0, 2, 5, 0, 2, 5};

    initial begin
        // single request on ch2, then PL ordering of channels 1,4,0
        tbl[0]  = mk(7'h04, 7'h04, 14'h0010, 1'b0, 7'h04, 2, 7'h00);
        tbl[1]  = mk(7'h04, 7'h04, 14'h0010, 1'b0, 7'h04, 2, 7'h00);
        tbl[2]  = mk(7'h04, 7'h04, 14'h0010, 1'b0, 7'h04, 2, 7'h00);
        tbl[3]  = mk(7'h04, 7'h04, 14'h0010, 1'b0, 7'h04, 2, 7'h00);
        tbl[4]  = mk(7'h04, 7'h04, 14'h0010, 1'b0, 7'h04, 2, 7'h00);
        tbl[5]  = mk(7'h04, 7'h04, 14'h0010, 1'b1, 7'h00, 0, 7'h04);
        tbl[6]  = mk(7'h04, 7'h00, 14'h0010, 1'b0, 7'h00, 0, 7'h00);
        tbl[7]  = mk(7'h04, 7'h00, 14'h0010, 1'b0, 7'h00, 0, 7'h00);
        tbl[8]  = mk(7'h7F, 7'h13, 14'h020D, 1'b0, 7'h02, 1, 7'h00);
        tbl[9]  = mk(7'h7F, 7'h13, 14'h020D, 1'b1, 7'h00, 0, 7'h02);
        tbl[10] = mk(7'h7F, 7'h11, 14'h020D, 1'b0, 7'h00, 0, 7'h00);
        tbl[11] = mk(7'h7F, 7'h11, 14'h020D, 1'b0, 7'h10, 4, 7'h00);
        tbl[12] = mk(7'h7F, 7'h11, 14'h020D, 1'b1, 7'h00, 0, 7'h10);
        tbl[13] = mk(7'h7F, 7'h01, 14'h020D, 1'b0, 7'h00, 0, 7'h00);
        tbl[14] = mk(7'h7F, 7'h01, 14'h020D, 1'b0, 7'h01, 0, 7'h00);
        tbl[15] = mk(7'h7F, 7'h01, 14'h020D, 1'b1, 7'h00, 0, 7'h01);
        tbl[16] = mk(7'h7F, 7'h00, 14'h020D, 1'b0, 7'h00, 0, 7'h00);
        tbl[17] = mk(7'h7F, 7'h00, 14'h020D, 1'b0, 7'h00, 0, 7'h00);

        apply_reset();
        check("reset", ex(7'h00, 0, 7'h00, 7'h00));

        for (int r = 0; r < 18; r++) begin
            ch_en = tbl[r].en; ch_req = tbl[r].req; ch_pl = tbl[r].pl;
            done = tbl[r].dn; err = tbl[r].er;
            step();
            check($sformatf("table[%0d]", r), ex(tbl[r].x_gnt, tbl[r].x_id, tbl[r].x_ack, tbl[r].x_err));
        end
        done = 1'b0;

        // round-robin among equal-PL channels 0,2,5 with requests held
        apply_reset();
        ch_en = 7'h25; ch_req = 7'h25; ch_pl = 14'h0411;
        for (int n = 0; n < 6; n++) begin
            step();
            check("rr_grant", ex(oh(rr_exp[n]), rr_exp[n], 7'h00, 7'h00));
            step();
            check("rr_hold", ex(oh(rr_exp[n]), rr_exp[n], 7'h00, 7'h00));
            done = 1'b1;
            step();
            check("rr_ack", ex(7'h00, 0, oh(rr_exp[n]), 7'h00));
            done = 1'b0;
            step();
            check("rr_gap", ex(7'h00, 0, 7'h00, 7'h00));
        end

        // watchdog timeout on channel 3
        apply_reset();
        ch_en = 7'h08; ch_req = 7'h08; ch_pl = '0;
        step();
        check("to_grant", ex(7'h08, 3, 7'h00, 7'h00));
        for (int k = 1; k < TO; k++) begin
            step();
            check($sformatf("to_hold%0d", k), ex(7'h08, 3, 7'h00, 7'h00));
        end
        step();
        check("to_err", ex(7'h00, 0, 7'h00, 7'h08));
        ch_req = '0;
        step();
        check("to_gap", ex(7'h00, 0, 7'h00, 7'h00));

        // error and done together: error wins, no ack
        ch_req = 7'h08;
        step();
        check("ed_grant", ex(7'h08, 3, 7'h00, 7'h00));
        done = 1'b1; err = 1'b1;
        step();
        check("ed_err", ex(7'h00, 0, 7'h00, 7'h08));
        done = 1'b0; err = 1'b0; ch_req = '0;
        step();
        check("ed_gap", ex(7'h00, 0, 7'h00, 7'h00));

        // abort by clearing enable of granted channel 6
        ch_en = 7'h7F; ch_req = 7'h42; ch_pl = 14'h3000;
        step();
        check("ab_grant", ex(7'h40, 6, 7'h00, 7'h00));
        step();
        check("ab_hold", ex(7'h40, 6, 7'h00, 7'h00));
        ch_en = 7'h3F;
        step();
        check("ab_drop", ex(7'h00, 0, 7'h00, 7'h00));
        step();
        check("ab_gap", ex(7'h00, 0, 7'h00, 7'h00));
        step();
        check("ab_next", ex(7'h02, 1, 7'h00, 7'h00));
        done = 1'b1;
        step();
        check("ab_ack", ex(7'h00, 0, 7'h02, 7'h00));
        done = 1'b0; ch_req = '0;
        step();
        step();

        // move rr_ptr to 5, then reset during a grant
        ch_en = 7'h7F; ch_req = 7'h10; ch_pl = '0;
        step();
        check("rs_g4", ex(7'h10, 4, 7'h00, 7'h00));
        done = 1'b1;
        step();
        done = 1'b0; ch_req = 7'h04;
        step();
        step();
        check("rs_g2", ex(7'h04, 2, 7'h00, 7'h00));
        rst_n = 1'b0;
        #1;
        check("rs_async", ex(7'h00, 0, 7'h00, 7'h00));
        ch_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ch_req = 7'h21;
        step();
        check("rs_rrptr", ex(7'h01, 0, 7'h00, 7'h00));

        // randomized traffic against the model
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 40 == 0) ch_en = CH'($urandom) | CH'($urandom);
            ch_req = CH'($urandom);
            ch_pl  = (2*CH)'($urandom);
            done   = ((cyc / 100) % 3 == 2) ? 1'b0 : ($urandom_range(3) == 0);
            err    = ($urandom_range(31) == 0);
            model_step();
            step();
            check("random", ex(m_busy ? oh(m_id) : 7'h00, m_id, m_ack, m_err));
        end
        done = 1'b0; err = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
